// File: rtl/matmul_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction decoder side and the
// matmul sequencer: start/abort in, memory read, array and result-select controls out.
interface matmul_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] mema_read_enable;
  logic [7:0] mema_read_elem;
  logic [3:0] memb_read_enable;
  logic [7:0] memb_read_elem;
  logic       array_write_enable;
  logic [1:0] array_output_row;
  logic [1:0] array_output_col;
  logic       result_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, abort,
    input  mema_read_enable, mema_read_elem, memb_read_enable, memb_read_elem,
    input  array_write_enable, array_output_row, array_output_col,
    input  result_valid, busy, done
  );

  modport slave (
    input  start, abort,
    output mema_read_enable, mema_read_elem, memb_read_enable, memb_read_elem,
    output array_write_enable, array_output_row, array_output_col,
    output result_valid, busy, done
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences one 4x4 systolic matrix multiply: skewed operand feed, accumulate drain,
// then a row-major sweep of the result select. Every output is registered.
module matmul_sequencer #(
  parameter int DIM       = 4,
  parameter int DRAIN_CYC = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  matmul_sequencer_if.slave   bus
);

  localparam int FEED_LAST = 2*DIM - 2;
  localparam int SLOTS     = DIM*DIM;
  localparam int CNT_W     = $clog2(FEED_LAST + DRAIN_CYC + SLOTS + 1);
  localparam int HOLD_W    = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [HOLD_W-1:0] hold, hold_d;

  logic [3:0] rd_en_q, rd_en_d;
  logic [7:0] rd_elem_q, rd_elem_d;
  logic       we_q, we_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hold_d  = hold;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt == CNT_W'(FEED_LAST)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
          state_d = S_READOUT;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_READOUT: begin
        if (hold == HOLD_W'(HOLD_CYC - 1)) begin
          hold_d = '0;
          if (cnt == CNT_W'(SLOTS - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          hold_d = hold + HOLD_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase

    if (state != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hold_d  = '0;
    end

    // Outputs are decoded from the next state so they land in registers on the same edge.
    rd_en_d   = '0;
    rd_elem_d = '0;
    we_d      = 1'b0;
    row_d     = '0;
    col_d     = '0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_FEED: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        for (int i = 0; i < DIM; i++) begin
          if (int'(cnt_d) >= i && int'(cnt_d) <= i + DIM - 1) begin
            rd_en_d[i]         = 1'b1;
            rd_elem_d[2*i +: 2] = 2'(int'(cnt_d) - i);
          end
        end
      end
      S_DRAIN: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_READOUT: begin
        busy_d         = 1'b1;
        valid_d        = 1'b1;
        {row_d, col_d} = 4'(cnt_d);
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold      <= '0;
      rd_en_q   <= '0;
      rd_elem_q <= '0;
      we_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hold      <= hold_d;
      rd_en_q   <= rd_en_d;
      rd_elem_q <= rd_elem_d;
      we_q      <= we_d;
      row_q     <= row_d;
      col_q     <= col_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // A and B share one skew pattern: row i of A meets column i of B.
  assign bus.mema_read_enable   = rd_en_q;
  assign bus.mema_read_elem     = rd_elem_q;
  assign bus.memb_read_enable   = rd_en_q;
  assign bus.memb_read_elem     = rd_elem_q;
  assign bus.array_write_enable = we_q;
  assign bus.array_output_row   = row_q;
  assign bus.array_output_col   = col_q;
  assign bus.result_valid       = valid_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: table-driven cycle vectors, an operand-memory plus
// systolic-array model feeding a result scoreboard, and abort/reset corner sequences.
module tb_matmul_sequencer;

  logic clk;
  logic rst_n;

  matmul_sequencer_if bus();
  matmul_sequencer_if bus2();

  matmul_sequencer #(.DIM(4), .DRAIN_CYC(4), .HOLD_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  matmul_sequencer #(.DIM(4), .DRAIN_CYC(4), .HOLD_CYC(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_a();
    return 32'({bus.mema_read_enable, bus.mema_read_elem, bus.array_write_enable,
                bus.array_output_row, bus.array_output_col, bus.result_valid,
                bus.busy, bus.done});
  endfunction

  function automatic logic [31:0] pack_b();
    return 32'({bus.memb_read_enable, bus.memb_read_elem, bus.array_write_enable,
                bus.array_output_row, bus.array_output_col, bus.result_valid,
                bus.busy, bus.done});
  endfunction

  function automatic logic [31:0] pack2();
    return 32'({bus2.mema_read_enable, bus2.mema_read_elem, bus2.memb_read_enable,
                bus2.memb_read_elem, bus2.array_write_enable, bus2.array_output_row,
                bus2.array_output_col, bus2.result_valid, bus2.busy, bus2.done});
  endfunction

  // Memories: A = identity, B[r][c] = 4r+c+1; output-stationary array, A flows right, B down.
  logic clr;
  int   acc   [4][4];
  int   a_reg [4][4];
  int   b_reg [4][4];

  function automatic int a_in(int i);
    int e;
    e = int'(bus.mema_read_elem[2*i +: 2]);
    return bus.mema_read_enable[i] ? ((i == e) ? 1 : 0) : 0;
  endfunction

  function automatic int b_in(int j);
    int e;
    e = int'(bus.memb_read_elem[2*j +: 2]);
    return bus.memb_read_enable[j] ? (e*4 + j + 1) : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (clr) begin
          acc[i][j]   <= 0;
          a_reg[i][j] <= 0;
          b_reg[i][j] <= 0;
        end else begin
          if (j == 0) a_reg[i][j] <= a_in(i);
          else        a_reg[i][j] <= a_reg[i][j-1];
          if (i == 0) b_reg[i][j] <= b_in(j);
          else        b_reg[i][j] <= b_reg[i-1][j];
          if (bus.array_write_enable) acc[i][j] <= acc[i][j] + a_reg[i][j]*b_reg[i][j];
        end
      end
    end
  end

  typedef struct {
    int         off;
    logic [3:0] en;
    logic [7:0] elem;
    logic       we;
    logic [1:0] row;
    logic [1:0] col;
    logic       valid;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [13];
  int   sb  [$];

  function automatic vec_t mk(int off, logic [3:0] en, logic [7:0] elem, logic we,
                              logic [1:0] row, logic [1:0] col, logic valid,
                              logic busy, logic done);
    vec_t v;
    v.off = off; v.en = en; v.elem = elem; v.we = we; v.row = row; v.col = col;
    v.valid = valid; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic run_seq(input string tag);
    int ti, we_cnt, v_cnt, done_off, v2_cnt, done2_off, expv, slot;
    logic [31:0] expk;
    ti = 0; we_cnt = 0; v_cnt = 0; done_off = -1; v2_cnt = 0; done2_off = -1;
    sb.delete();
    for (int k = 1; k <= 16; k++) sb.push_back(k);
    clr = 1'b1;
    bus.start = 1'b1;
    bus2.start = 1'b1;
    step();
    clr = 1'b0;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    for (int off = 0; off <= 46; off++) begin
      if (ti < 13 && tbl[ti].off == off) begin
        expk = 32'({tbl[ti].en, tbl[ti].elem, tbl[ti].we, tbl[ti].row, tbl[ti].col,
                    tbl[ti].valid, tbl[ti].busy, tbl[ti].done});
        chk($sformatf("%s_vec%0d_a", tag, off), pack_a(), expk);
        chk($sformatf("%s_vec%0d_b", tag, off), pack_b(), expk);
        ti++;
      end
      if (bus.array_write_enable) we_cnt++;
      if (bus.done && done_off < 0) done_off = off;
      if (bus.result_valid) begin
        v_cnt++;
        if (sb.size() > 0) begin
          expv = sb.pop_front();
          chk($sformatf("%s_result%0d", tag, v_cnt),
              32'(acc[bus.array_output_row][bus.array_output_col]), 32'(expv));
        end else begin
          chk($sformatf("%s_sb_underflow", tag), 32'(sb.size()), 32'd1);
        end
      end
      if (bus2.result_valid) begin
        v2_cnt++;
        slot = (off - 11) / 2;
        chk($sformatf("%s_hold2_sel%0d", tag, off),
            32'({bus2.array_output_row, bus2.array_output_col}), 32'(slot));
      end
      if (bus2.done && done2_off < 0) done2_off = off;
      bus.start = (off == 3);
      step();
    end
    bus.start = 1'b0;
    chk({tag, "_we_cycles"},     32'(we_cnt),    32'd11);
    chk({tag, "_valid_cycles"},  32'(v_cnt),     32'd16);
    chk({tag, "_done_offset"},   32'(done_off),  32'd27);
    chk({tag, "_sb_empty"},      32'(sb.size()), 32'd0);
    chk({tag, "_hold2_valid"},   32'(v2_cnt),    32'd32);
    chk({tag, "_hold2_done"},    32'(done2_off), 32'd43);
    chk({tag, "_hold2_idle"},    pack2(),        32'd0);
  endtask

  initial begin
    int saw_done;
    tbl[0]  = mk(0,  4'h1, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(1,  4'h3, 8'h01, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(3,  4'hF, 8'h1B, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(4,  4'hE, 8'h6C, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(6,  4'h8, 8'hC0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(7,  4'h0, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(10, 4'h0, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(11, 4'h0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    tbl[8]  = mk(12, 4'h0, 8'h00, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(16, 4'h0, 8'h00, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(26, 4'h0, 8'h00, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(27, 4'h0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(28, 4'h0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    clr = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    step();
    step();
    chk("reset_a", pack_a(), 32'd0);
    chk("reset_2", pack2(),  32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", pack_a(), 32'd0);

    // abort and start together in IDLE: abort wins
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_over_start", pack_a(), 32'd0);
    step();
    chk("abort_over_start_hold", pack_a(), 32'd0);

    run_seq("seq1");

    // abort during READOUT slot 5
    sb.delete();
    clr = 1'b1;
    bus.start = 1'b1;
    step();
    clr = 1'b0;
    bus.start = 1'b0;
    repeat (16) step();
    chk("abort_at_slot5", 32'({bus.result_valid, bus.array_output_row, bus.array_output_col}),
        32'h15);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_idle", pack_a(), 32'd0);
    saw_done = 0;
    repeat (20) begin
      step();
      if (bus.done || bus.busy) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    run_seq("seq2");

    // asynchronous reset in the middle of FEED
    bus.start = 1'b1;
    bus2.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) step();
    chk("prereset_feed", 32'(bus.mema_read_enable), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", pack_a(), 32'd0);
    chk("async_reset_2", pack2(),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_idle", pack_a(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
